// File: rtl/keyboard_move_ctl.sv
// PS/2 keyboard front end for the player movement controller: conditions the PS/2
// lines, receives scancode-set-2 bytes and turns A/D/LEFT/RIGHT make/break into held levels.
`timescale 1ns/1ps
module keyboard_move_ctl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       m_left,
  output logic       m_right,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       frame_err
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_e;

  typedef struct packed {
    logic a;
    logic d;
    logic left;
    logic right;
  } keys_t;

  logic [1:0]        clk_sync_q;
  logic [1:0]        data_sync_q;
  logic              filt_q;
  logic [FILT_W-1:0] filt_cnt_q;
  logic              fall_tick_q;

  rx_state_e         rx_state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              code_valid_q;
  logic [7:0]        code_q;
  logic              frame_err_q;

  dec_state_e        dec_q, dec_d;
  keys_t             keys_q, keys_d;
  logic              m_left_q, m_right_q;
  logic              left_req_d, right_req_d;
  logic              rx_data;

  assign rx_data = data_sync_q[1];

  // Synchronisers preset to the idle-bus level; a ps2_clk level change is
  // accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_tick_q <= 1'b0;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, regardless of statement order.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      fall_tick_q <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_q      <= clk_sync_q[1];
        filt_cnt_q  <= '0;
        fall_tick_q <= filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (rx_state_q == RX_IDLE || fall_tick_q) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (rx_state_q != RX_IDLE && !fall_tick_q &&
          to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_q <= 1'b1;
        rx_state_q  <= RX_IDLE;
        shift_q     <= '0;
      end else if (fall_tick_q) begin
        unique case (rx_state_q)
          RX_IDLE: begin
            if (!rx_data) begin
              rx_state_q <= RX_DATA;
              bit_cnt_q  <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {rx_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q   <= rx_data;
            rx_state_q <= RX_STOP;
          end
          RX_STOP: begin
            // Odd parity over data+parity, and the stop bit must be high.
            if (rx_data && (^{shift_q, parity_q})) begin
              code_valid_q <= 1'b1;
              code_q       <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  function automatic keys_t apply_key(keys_t k, logic [7:0] c, logic ext, logic make);
    keys_t r;
    r = k;
    if (!ext && c == 8'h1C) r.a     = make;
    if (!ext && c == 8'h23) r.d     = make;
    if ( ext && c == 8'h6B) r.left  = make;
    if ( ext && c == 8'h74) r.right = make;
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec_d  = dec_q;
    keys_d = keys_q;
    if (frame_err_q) begin
      dec_d = DEC_IDLE;
    end else if (code_valid_q) begin
      unique case (dec_q)
        DEC_IDLE: begin
          if (code_q == 8'hE0)      dec_d = DEC_E0;
          else if (code_q == 8'hF0) dec_d = DEC_F0;
          else                      keys_d = apply_key(keys_q, code_q, 1'b0, 1'b1);
        end
        DEC_E0: begin
          if (code_q == 8'hF0) begin
            dec_d = DEC_E0F0;
          end else begin
            keys_d = apply_key(keys_q, code_q, 1'b1, 1'b1);
            dec_d  = DEC_IDLE;
          end
        end
        DEC_F0: begin
          keys_d = apply_key(keys_q, code_q, 1'b0, 1'b0);
          dec_d  = DEC_IDLE;
        end
        DEC_E0F0: begin
          keys_d = apply_key(keys_q, code_q, 1'b1, 1'b0);
          dec_d  = DEC_IDLE;
        end
        default: dec_d = DEC_IDLE;
      endcase
    end
    left_req_d  = keys_d.a | keys_d.left;
    right_req_d = keys_d.d | keys_d.right;
  end

  // Outputs are registered from the next-state flags so they move one cycle
  // after code_valid; opposing requests cancel and the player stops.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q     <= DEC_IDLE;
      keys_q    <= '0;
      m_left_q  <= 1'b0;
      m_right_q <= 1'b0;
    end else begin
      dec_q     <= dec_d;
      keys_q    <= keys_d;
      m_left_q  <= left_req_d & ~right_req_d;
      m_right_q <= right_req_d & ~left_req_d;
    end
  end

  assign m_left     = m_left_q;
  assign m_right    = m_right_q;
  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign frame_err  = frame_err_q;

endmodule
